// File: rtl/hls_ctrl_pkg.sv
// Shared types and defaults for the ap_ctrl_hs call master and its helpers.
// Mask bit positions follow the rsp_vld_mask port order {out31,out30,out13}.
package hls_ctrl_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int N_IN_DEF    = 20;
    localparam int KEY_W_DEF   = 255;
    localparam int TIMEOUT_DEF = 64;

    localparam int VLD_OUT13 = 0;
    localparam int VLD_OUT30 = 1;
    localparam int VLD_OUT31 = 2;
    localparam int VLD_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALL = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } ctrl_state_e;

    function automatic int wd_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/hls_watchdog.sv
// Call watchdog: saturating cycle counter, cleared between calls, that raises
// expire while enabled and the count has reached TIMEOUT-1.
module hls_watchdog
    import hls_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = wd_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [CW-1:0] cnt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt >= CNT_LAST);

endmodule

// File: rtl/hls_ap_ctrl_master.sv
// ap_ctrl_hs initiator for locked HLS cores: one command in, one ap_start call,
// one response out; owns the out30 in/out register and aborts hung calls.
module hls_ap_ctrl_master
    import hls_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_IN    = N_IN_DEF,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [N_IN*DATA_W-1:0]   cmd_data,
    input  logic [KEY_W-1:0]         key_in,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_out13,
    output logic [DATA_W-1:0]        rsp_out30,
    output logic [DATA_W-1:0]        rsp_out31,
    output logic [VLD_W-1:0]         rsp_vld_mask,
    output logic                     rsp_timeout,
    output logic                     core_start,
    input  logic                     core_done,
    input  logic                     core_idle,
    input  logic                     core_ready,
    output logic [N_IN*DATA_W-1:0]   core_in,
    output logic [KEY_W-1:0]         core_key,
    input  logic [DATA_W-1:0]        core_out13,
    input  logic [DATA_W-1:0]        core_out30_o,
    input  logic [DATA_W-1:0]        core_out31,
    input  logic                     core_out13_vld,
    input  logic                     core_out30_vld,
    input  logic                     core_out31_vld,
    output logic [DATA_W-1:0]        core_out30_i
);

    ctrl_state_e state_q, state_d;
    logic        wd_clr, wd_en, wd_expire;
    logic        cmd_fire, in_wait, done_wait, abort;

    // ap_idle carries no information the handshake does not already give us.
    logic unused_idle;
    assign unused_idle = core_idle;

    hls_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (wd_clr),
        .en       (wd_en),
        .expire   (wd_expire)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid)                    state_d = ST_CALL;
            ST_CALL: if (wd_expire)                    state_d = ST_RESP;
                     else if (core_ready || core_done) state_d = ST_WAIT;
            ST_WAIT: if (core_done || wd_expire)       state_d = ST_RESP;
            ST_RESP: if (rsp_ready)                    state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        core_start = (state_q == ST_CALL);
        rsp_valid  = (state_q == ST_RESP);
        wd_clr     = (state_q == ST_IDLE);
        wd_en      = (state_q == ST_CALL) || (state_q == ST_WAIT);
    end

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign in_wait   = (state_q == ST_WAIT);
    assign done_wait = in_wait && core_done;
    // A done arriving on the expiry cycle still counts as a normal completion.
    assign abort     = wd_expire && !done_wait;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            core_in      <= '0;
            core_key     <= '0;
            rsp_out13    <= '0;
            rsp_out30    <= '0;
            rsp_out31    <= '0;
            rsp_vld_mask <= '0;
            rsp_timeout  <= 1'b0;
            core_out30_i <= '0;
        end else begin
            if (cmd_fire) begin
                core_in      <= cmd_data;
                core_key     <= key_in;
                rsp_vld_mask <= '0;
                rsp_timeout  <= 1'b0;
            end
            if (in_wait && core_out13_vld) begin
                rsp_out13              <= core_out13;
                rsp_vld_mask[VLD_OUT13] <= 1'b1;
            end
            if (in_wait && core_out30_vld) begin
                rsp_out30              <= core_out30_o;
                core_out30_i           <= core_out30_o;
                rsp_vld_mask[VLD_OUT30] <= 1'b1;
            end
            if (in_wait && core_out31_vld) begin
                rsp_out31              <= core_out31;
                rsp_vld_mask[VLD_OUT31] <= 1'b1;
            end
            if (abort) rsp_timeout <= 1'b1;
        end
    end

endmodule
